mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Sequences one external 1-stage-pipelined MAC unit (mac_unit) through a full dot product of two
//  VEC_LEN-element vectors held in single-port operand memories. Fetches operands, drives the MAC,
//  accumulates mac_data into a wide running sum, adds a bias and returns the result over a
//  valid/ready handshake. Sits between the layer scheduler (start/result) and the neuron datapath.
// PARAMETERS
//  ADDR_W  8   operand memory address width; max vector length 2**ADDR_W
//  RES_W   16  result width presented on res_data
// PORTS
//  clk          in   1                  single clock, all logic on posedge
//  rst_n        in   1                  synchronous, active-HIGH reset (high = reset, despite name)
//  start        in   1                  pulse: begin dot product (sampled in IDLE only)
//  vec_len      in   ADDR_W+1           element count, sampled with start; 0 allowed
//  bias         in   DATA_WIDTH         signed bias, sampled with start
//  busy         out  1                  high in FETCH/DRAIN/DONE
//  mem_rd_en    out  1                  operand memory read strobe
//  mem_rd_addr  out  ADDR_W             element index; both memories share it
//  mem_a_data   in   DATA_WIDTH         operand A, valid 1 cycle after mem_rd_en
//  mem_b_data   in   DATA_WIDTH         operand B, valid 1 cycle after mem_rd_en
//  mac_enable   out  1                  to mac_unit enable
//  mac_op1      out  DATA_WIDTH         to mac_unit operand_1
//  mac_op2      out  DATA_WIDTH         to mac_unit operand_2
//  mac_pre_add  out  DATA_WIDTH         to mac_unit pre_adder_input
//  mac_data     in   ACC_DATA_WIDTH     from mac_unit
//  res_valid    out  1                  result available
//  res_ready    in   1                  consumer accepts result
//  res_data     out  RES_W              signed dot product + bias
// BEHAVIOUR
//  - Reset: state IDLE; busy, mem_rd_en, mac_enable, res_valid = 0; mem_rd_addr, mac_op*,
//    mac_pre_add, res_data = 0; accumulator and tag pipe cleared. Reset mid-operation aborts
//    at the next edge; any result in flight is discarded.
//  - FSM: IDLE -start&&vec_len!=0-> FETCH; IDLE -start&&vec_len==0-> DONE (res_data=0).
//    FETCH: one read per cycle, addr 0..vec_len-1; after last address -> DRAIN.
//    DRAIN: exactly 3 cycles, no reads -> DONE. DONE: hold res_valid/res_data until res_ready,
//    then IDLE. start outside IDLE is ignored.
//  - Timing (element k addressed in cycle a): mac_op1/op2 = mem data in a+1; mac_unit mul_reg in a+2;
//    mac_data carries product k in a+3. A 3-deep valid/first tag pipe tracks each element.
//  - mac_pre_add = bias in the cycle whose mul_reg holds element 0 (tag stage 2 first-flag), else 0;
//    mac_op1/op2 = 0 when tag stage 1 invalid.
//  - mac_enable high from first FETCH cycle through last DRAIN cycle; low otherwise (MAC self-clears).
//  - Accumulator width ACC_DATA_WIDTH+ADDR_W (no internal overflow); adds sign-extended mac_data
//    when tag stage 3 valid; cleared on start.
//  - Latency: res_valid rises vec_len+4 cycles after the start cycle; throughput 1 element/cycle.
//  - res_data registered; stable while res_valid && !res_ready.
// CONFIGURATION
//  MAC_SEQ_SAT_EN defined: res_data = accumulator clamped to [-2**(RES_W-1), 2**(RES_W-1)-1].
//  Not defined: res_data = low RES_W bits of accumulator (two's-complement wrap).
// STRUCTURE
//  top_pkg: DATA_WIDTH, ACC_DATA_WIDTH (existing), typedef enum mac_seq_state_t
//  {IDLE,FETCH,DRAIN,DONE}, typedef struct mac_tag_t {valid, first}.
//  One sub-module: mac_tag_pipe (3-stage mac_tag_t shift register, sync clear).
//  mac_unit stays external; bench instantiates it alongside.
// TESTING
//  1 basic: vec_len=4, A={1,2,3,4}, B={5,6,7,8}, bias=10, start@cycle0 -> res_valid@cycle8, res_data=80.
//  2 negatives: vec_len=3, A={-3,4,-5}, B={7,-2,-1}, bias=-1 -> res_data=-25.
//  3 zero length: vec_len=0, bias=9 -> no mem_rd_en, no mac_enable, res_valid next cycle, res_data=0.
//  4 backpressure/ignore: hold res_ready=0 10 cycles, pulse start in FETCH and DONE -> res_data stable,
//    single result, extra starts ignored; res_ready=1 -> IDLE next cycle.
//  5 overflow (RES_W=16): vec_len=4, A=B=all 127, bias=0 -> 32767 with MAC_SEQ_SAT_EN, -1020 without.
//  6 reset mid-run: assert rst_n high during FETCH cycle 3 of vec_len=8 -> next cycle all outputs 0,
//    IDLE; fresh start with test-1 data -> 80.

Source files
------------

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and datapath widths for the MAC sequencer.
package mac_seq_ctrl_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned ACC_DATA_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } mac_seq_state_t;

  // Per-element tag travelling alongside the MAC pipeline
  typedef struct packed {
    logic valid;
    logic first;
  } mac_tag_t;

endpackage

// File: rtl/mac_seq_ctrl_tag_pipe.sv
// mac_tag_pipe: 3-stage valid/first tag shift register that tracks operands through the MAC.
module mac_tag_pipe
  import mac_seq_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  mac_tag_t tag_in,
  output logic     tag1_valid,
  output mac_tag_t tag2,
  output mac_tag_t tag3
);

  mac_tag_t [2:0] stage;

  // Shift one stage per cycle; synchronous clear drops everything in flight
  always_ff @(posedge clk) begin
    if (clr) begin
      stage <= '0;
    end else begin
      stage <= {stage[1:0], tag_in};
    end
  end

  assign tag1_valid = stage[0].valid;
  assign tag2       = stage[1];
  assign tag3       = stage[2];

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences an external 1-stage-pipelined MAC through a dot product of two
// operand memories, accumulates, adds bias and returns the result over valid/ready.
// Build option: define MAC_SEQ_SAT_EN to saturate res_data instead of wrapping it.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RES_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W:0]           vec_len,
  input  logic [DATA_WIDTH-1:0]     bias,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_a_data,
  input  logic [DATA_WIDTH-1:0]     mem_b_data,
  output logic                      mac_enable,
  output logic [DATA_WIDTH-1:0]     mac_op1,
  output logic [DATA_WIDTH-1:0]     mac_op2,
  output logic [DATA_WIDTH-1:0]     mac_pre_add,
  input  logic [ACC_DATA_WIDTH-1:0] mac_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RES_W-1:0]          res_data
);

  localparam int unsigned ACC_W = ACC_DATA_WIDTH + ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  mac_seq_state_t           state;
  logic [ADDR_W-1:0]        last_addr;
  logic [1:0]               drain_cnt;
  logic [DATA_WIDTH-1:0]    bias_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  mac_ext;
  logic [RES_W-1:0]         res_next;
  mac_tag_t                 tag_in;
  logic                     tag1_valid;
  mac_tag_t                 tag2;
  mac_tag_t                 tag3;

  // Tag each read as it is issued; the first read of a run is address 0
  assign tag_in.valid = mem_rd_en;
  assign tag_in.first = mem_rd_en && (mem_rd_addr == '0);

  mac_tag_pipe u_tag_pipe (
    .clk        (clk),
    .clr        (rst_n),
    .tag_in     (tag_in),
    .tag1_valid (tag1_valid),
    .tag2       (tag2),
    .tag3       (tag3)
  );

  // Memory data goes straight to the MAC the cycle it arrives; bias rides with element 0
  assign mac_op1     = tag1_valid ? mem_a_data : '0;
  assign mac_op2     = tag1_valid ? mem_b_data : '0;
  assign mac_pre_add = (tag2.valid && tag2.first) ? bias_q : '0;

  assign mac_ext = {{ADDR_W{mac_data[ACC_DATA_WIDTH-1]}}, mac_data};

  // Running sum: load on the first element of a run, add on the rest
  always_comb begin
    acc_sum = acc;
    if (tag3.valid) begin
      acc_sum = (tag3.first ? '0 : acc) + mac_ext;
    end
  end

`ifdef MAC_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (RES_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(64'sd1 <<< (RES_W - 1)));

  // Clamp the final sum into the signed result range
  always_comb begin
    res_next = acc_sum[RES_W-1:0];
    if (acc_sum > SAT_HI) begin
      res_next = SAT_HI[RES_W-1:0];
    end else if (acc_sum < SAT_LO) begin
      res_next = SAT_LO[RES_W-1:0];
    end
  end
`else
  // Two's-complement wrap of the final sum
  always_comb begin
    res_next = acc_sum[RES_W-1:0];
  end
`endif

  // Sequencer FSM with registered control and result outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mac_enable  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      acc         <= '0;
      last_addr   <= '0;
      drain_cnt   <= '0;
      bias_q      <= '0;
    end else begin
      acc <= acc_sum;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            bias_q    <= bias;
            last_addr <= ADDR_W'(vec_len - LEN_W'(1));
            busy      <= 1'b1;
            if (vec_len != '0) begin
              state       <= FETCH;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= '0;
              mac_enable  <= 1'b1;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= '0;
            end
          end
        end
        FETCH: begin
          if (mem_rd_addr == last_addr) begin
            state       <= DRAIN;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            drain_cnt   <= '0;
          end else begin
            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state      <= DONE;
            mac_enable <= 1'b0;
            res_valid  <= 1'b1;
            res_data   <= res_next;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: operand memories and a 1-stage MAC model around the DUT,
// directed cases plus random vectors checked against a plain-arithmetic dot product.
// Honours MAC_SEQ_SAT_EN for the expected result format.
module tb_mac_seq_ctrl;
  import mac_seq_ctrl_pkg::*;

  localparam int ADDR_W = 8;
  localparam int RES_W  = 16;

  logic                             clk;
  logic                             rst_n;
  logic                             start;
  logic [ADDR_W:0]                  vec_len;
  logic [DATA_WIDTH-1:0]            bias;
  logic                             busy;
  logic                             mem_rd_en;
  logic [ADDR_W-1:0]                mem_rd_addr;
  logic signed [DATA_WIDTH-1:0]     mem_a_data;
  logic signed [DATA_WIDTH-1:0]     mem_b_data;
  logic                             mac_enable;
  logic signed [DATA_WIDTH-1:0]     mac_op1;
  logic signed [DATA_WIDTH-1:0]     mac_op2;
  logic signed [DATA_WIDTH-1:0]     mac_pre_add;
  logic signed [ACC_DATA_WIDTH-1:0] mac_data;
  logic                             res_valid;
  logic                             res_ready;
  logic signed [RES_W-1:0]          res_data;

  logic signed [DATA_WIDTH-1:0] mem_a [256];
  logic signed [DATA_WIDTH-1:0] mem_b [256];
  logic signed [15:0]           mul_reg;

  int n_cmp = 0;
  int n_err = 0;

  mac_seq_ctrl #(.ADDR_W(ADDR_W), .RES_W(RES_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vec_len     (vec_len),
    .bias        (bias),
    .busy        (busy),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_a_data  (mem_a_data),
    .mem_b_data  (mem_b_data),
    .mac_enable  (mac_enable),
    .mac_op1     (mac_op1),
    .mac_op2     (mac_op2),
    .mac_pre_add (mac_pre_add),
    .mac_data    (mac_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read operand memories
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a_data <= mem_a[mem_rd_addr];
      mem_b_data <= mem_b[mem_rd_addr];
    end
  end

  // External MAC: product registered, then product + pre-add registered; clears when disabled
  always @(posedge clk) begin
    if (rst_n || !mac_enable) begin
      mul_reg  <= '0;
      mac_data <= '0;
    end else begin
      mul_reg  <= mac_op1 * mac_op2;
      mac_data <= mul_reg + mac_pre_add;
    end
  end

  // Expected result: bias + sum of products, then formatted to RES_W bits
  function automatic longint ref_dot(input int len, input longint b);
    longint s;
    longint lim;
    if (len == 0) return 0;
    s = b;
    for (int i = 0; i < len; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
    lim = longint'(1) <<< (RES_W - 1);
`ifdef MAC_SEQ_SAT_EN
    if (s > lim - 1) s = lim - 1;
    else if (s < -lim) s = -lim;
`else
    s = s & (2 * lim - 1);
    if (s >= lim) s -= 2 * lim;
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_rd_en"}, longint'(mem_rd_en), 0);
    chk({tag, "_rd_addr"}, longint'(mem_rd_addr), 0);
    chk({tag, "_mac_en"}, longint'(mac_enable), 0);
    chk({tag, "_op1"}, longint'(mac_op1), 0);
    chk({tag, "_op2"}, longint'(mac_op2), 0);
    chk({tag, "_pre_add"}, longint'(mac_pre_add), 0);
    chk({tag, "_res_valid"}, longint'(res_valid), 0);
    chk({tag, "_res_data"}, longint'(res_data), 0);
  endtask

  task automatic load_random(input int len);
    for (int i = 0; i < len; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  task automatic load_test1();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
  endtask

  // One full dot product: latency, read/enable counts, address order, result, hold, handoff
  task automatic run_dot(input string tag, input int len, input int b, input int hold,
                         input bit poke, output longint got);
    longint exp;
    int     lat;
    int     rd_cnt;
    int     en_cnt;
    int     addr_err;
    int     unstable;
    int     extra;
    logic signed [RES_W-1:0] snap;
    exp = ref_dot(len, longint'(b));
    @(posedge clk); #1;
    start     = 1'b1;
    vec_len   = 9'(len);
    bias      = 8'(b);
    res_ready = 1'b0;
    @(posedge clk); #1;
    start    = 1'b0;
    vec_len  = 9'($urandom_range(1, 255));
    bias     = 8'($urandom);
    lat      = 1;
    rd_cnt   = 0;
    en_cnt   = 0;
    addr_err = 0;
    while (!res_valid && lat < 400) begin
      if (mem_rd_en) begin
        if (mem_rd_addr != 8'(rd_cnt)) addr_err++;
        rd_cnt++;
      end
      if (mac_enable) en_cnt++;
      start = poke && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    got = longint'(res_data);
    chk({tag, "_latency"}, longint'(lat), (len == 0) ? 1 : len + 4);
    chk({tag, "_reads"}, longint'(rd_cnt), longint'(len));
    chk({tag, "_mac_en_cycles"}, longint'(en_cnt), (len == 0) ? 0 : len + 3);
    chk({tag, "_addr_order"}, longint'(addr_err), 0);
    chk({tag, "_busy"}, longint'(busy), 1);
    chk({tag, "_res"}, got, exp);
    snap     = res_data;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      start = poke && (i == 1);
      @(posedge clk); #1;
      if (!res_valid || !busy || res_data !== snap) unstable++;
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_hold_stable"}, longint'(unstable), 0);
    chk({tag, "_accept_valid"}, longint'(res_valid), 0);
    chk({tag, "_accept_busy"}, longint'(busy), 0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (res_valid || busy || mem_rd_en) extra++;
    end
    chk({tag, "_no_extra"}, longint'(extra), 0);
  endtask

  initial begin
    longint got;
    int     len;
    int     b;

    rst_n     = 1'b1;
    start     = 1'b0;
    vec_len   = '0;
    bias      = '0;
    res_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b0;

    // Basic dot product
    load_test1();
    run_dot("t1", 4, 10, 2, 1'b0, got);
    chk("t1_literal", got, 80);

    // Signed operands and negative bias
    mem_a[0] = -8'sd3; mem_a[1] = 8'sd4;  mem_a[2] = -8'sd5;
    mem_b[0] = 8'sd7;  mem_b[1] = -8'sd2; mem_b[2] = -8'sd1;
    run_dot("t2", 3, -1, 0, 1'b0, got);
    chk("t2_literal", got, -25);

    // Zero length
    run_dot("t3", 0, 9, 1, 1'b0, got);
    chk("t3_literal", got, 0);

    // Backpressure with ignored starts in FETCH and DONE
    load_random(6);
    run_dot("t4", 6, 3, 10, 1'b1, got);

    // Overflow of the result width
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'sd127;
      mem_b[i] = 8'sd127;
    end
    run_dot("t5", 4, 0, 1, 1'b0, got);
`ifdef MAC_SEQ_SAT_EN
    chk("t5_literal", got, 32767);
`else
    chk("t5_literal", got, -1020);
`endif

    // Reset during the third FETCH cycle of an 8-element run
    load_random(8);
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = 9'd8;
    bias    = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet("t6_reset");
    rst_n = 1'b0;
    load_test1();
    run_dot("t6_rerun", 4, 10, 0, 1'b0, got);
    chk("t6_literal", got, 80);

    // Full-length vector at the extreme operand value
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = -8'sd128;
      mem_b[i] = -8'sd128;
    end
    run_dot("full_len", 256, 7, 1, 1'b0, got);

    // Random vectors, lengths and backpressure
    for (int r = 0; r < 10; r++) begin
      len = int'($urandom_range(0, 20));
      b   = int'($urandom_range(0, 255)) - 128;
      load_random(len);
      run_dot($sformatf("rand%0d", r), len, b, int'($urandom_range(0, 4)), 1'($urandom), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
